// File: rtl/seg_scan_decoder_pkg.sv
// Shared definitions for the multiplexed 7-segment scan decoder: glyph codes,
// digit count, FSM encoding and small bit-vector helpers.
package seg_scan_decoder_pkg;

    localparam int NUM_DIGITS = 8;

    // Active-low segment patterns, bit6=g ... bit0=a
    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_HOLD   = 2'd2
    } scan_state_t;

    function automatic logic [3:0] pop_count8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    // Index of the highest set bit; only meaningful when exactly one bit is set
    function automatic logic [2:0] bit_index8(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg_scan_decoder_seg7_to_hex.sv
// Combinational decode of an active-low 7-segment pattern to its hex value;
// o_legal is low for any pattern that is not one of the 16 hex glyphs.
module seg7_to_hex
    import seg_scan_decoder_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic [3:0] o_value,
    output logic       o_legal
);

    always_comb begin
        o_value = 4'h0;
        o_legal = 1'b1;
        case (i_pattern)
            GLYPH_0: o_value = 4'h0;
            GLYPH_1: o_value = 4'h1;
            GLYPH_2: o_value = 4'h2;
            GLYPH_3: o_value = 4'h3;
            GLYPH_4: o_value = 4'h4;
            GLYPH_5: o_value = 4'h5;
            GLYPH_6: o_value = 4'h6;
            GLYPH_7: o_value = 4'h7;
            GLYPH_8: o_value = 4'h8;
            GLYPH_9: o_value = 4'h9;
            GLYPH_A: o_value = 4'hA;
            GLYPH_B: o_value = 4'hB;
            GLYPH_C: o_value = 4'hC;
            GLYPH_D: o_value = 4'hD;
            GLYPH_E: o_value = 4'hE;
            GLYPH_F: o_value = 4'hF;
            default: o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers the hex value shown on a scanned 8-digit 7-segment display by
// sampling the segment/enable lines once they have settled on each digit.
module seg_scan_decoder
    import seg_scan_decoder_pkg::*;
#(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 1048576
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [6:0]  i_out7,
    input  logic [7:0]  i_en_out,
    output logic [31:0] o_digits,
    output logic [7:0]  o_digit_valid,
    output logic        o_frame_done,
    output logic        o_seg_err,
    output logic        o_an_err,
    output logic        o_stale
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    logic [6:0]    r_out7;
    logic [7:0]    r_en;
    logic [7:0]    r_stab;
    scan_state_t   r_state;
    logic [31:0]   r_digits;
    logic [7:0]    r_valid;
    logic [7:0]    r_seen;
    logic          r_frame_done;
    logic          r_seg_err;
    logic          r_an_err;
    logic          r_stale;
    logic [TW-1:0] r_tmo;

    scan_state_t   w_state_next;
    logic          w_change;
    logic [7:0]    w_stab_next;
    logic          w_do_sample;
    logic [3:0]    w_value;
    logic          w_legal;
    logic [7:0]    w_active;
    logic [3:0]    w_low_cnt;
    logic [2:0]    w_idx;
    logic [7:0]    w_sel;
    logic          w_capture;
    logic          w_glyph_err;
    logic          w_multi_low;
    logic [7:0]    w_seen_next;
    logic          w_frame;

    seg7_to_hex u_seg7_to_hex (
        .i_pattern (r_out7),
        .o_value   (w_value),
        .o_legal   (w_legal)
    );

    // Change is seen as the new value enters the input register, so the
    // counter clears on the same edge the registered value moves.
    always_comb begin
        w_change    = (i_out7 != r_out7) || (i_en_out != r_en);
        w_stab_next = r_stab;
        if (w_change) begin
            w_stab_next = 8'd0;
        end else if (r_stab != 8'hFF) begin
            w_stab_next = r_stab + 8'd1;
        end else begin
            w_stab_next = r_stab;
        end
    end

    // Input capture register and stability counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out7 <= 7'h7F;
            r_en   <= 8'hFF;
            r_stab <= 8'd0;
        end else begin
            r_out7 <= i_out7;
            r_en   <= i_en_out;
            r_stab <= w_stab_next;
        end
    end

    // Scan FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_WAIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Scan FSM next state; SAMPLE acts on the stable registered inputs
    always_comb begin
        w_state_next = r_state;
        w_do_sample  = 1'b0;
        case (r_state)
            ST_WAIT: begin
                if (!w_change && (w_stab_next >= 8'(SETTLE))) begin
                    w_state_next = ST_SAMPLE;
                end else begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_SAMPLE: begin
                w_do_sample  = 1'b1;
                w_state_next = w_change ? ST_WAIT : ST_HOLD;
            end
            ST_HOLD: begin
                w_state_next = w_change ? ST_WAIT : ST_HOLD;
            end
            default: begin
                w_state_next = ST_WAIT;
            end
        endcase
    end

    // Classify the sampled enable word and glyph
    always_comb begin
        w_active    = ~r_en;
        w_low_cnt   = pop_count8(w_active);
        w_idx       = bit_index8(w_active);
        w_sel       = 8'd1 << w_idx;
        w_capture   = w_do_sample && (w_low_cnt == 4'd1) && w_legal;
        w_glyph_err = w_do_sample && (w_low_cnt == 4'd1) && !w_legal;
        w_multi_low = w_do_sample && (w_low_cnt > 4'd1);
        w_seen_next = r_seen | w_sel;
        w_frame     = w_capture && (w_seen_next == 8'hFF);
    end

    // Digit store, frame tracking, error pulses and stale timeout
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_digits     <= 32'd0;
            r_valid      <= 8'd0;
            r_seen       <= 8'd0;
            r_frame_done <= 1'b0;
            r_seg_err    <= 1'b0;
            r_an_err     <= 1'b0;
            r_stale      <= 1'b0;
            r_tmo        <= '0;
        end else begin
            r_frame_done <= w_frame;
            r_seg_err    <= w_glyph_err;
            r_an_err     <= w_multi_low;
            if (w_capture) begin
                r_digits[{w_idx, 2'b00} +: 4] <= w_value;
                r_valid <= r_valid | w_sel;
                r_seen  <= w_frame ? 8'd0 : w_seen_next;
                r_tmo   <= '0;
                r_stale <= 1'b0;
            end else if (r_tmo == TMO_LAST) begin
                r_tmo   <= TMO_MAX;
                r_stale <= 1'b1;
                r_valid <= 8'd0;
                r_seen  <= 8'd0;
            end else begin
                r_tmo   <= (r_tmo == TMO_MAX) ? r_tmo : r_tmo + TMO_ONE;
                r_valid <= w_glyph_err ? (r_valid & ~w_sel) : r_valid;
            end
        end
    end

    assign o_digits      = r_digits;
    assign o_digit_valid = r_valid;
    assign o_frame_done  = r_frame_done;
    assign o_seg_err     = r_seg_err;
    assign o_an_err      = r_an_err;
    assign o_stale       = r_stale;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: stimulus pushes expected output
// events, a negedge monitor pops and compares each observed event.
module tb_seg_scan_decoder;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 100;
    localparam int DWELL   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  out7 = 7'h7F;
    logic [7:0]  en_out = 8'hFF;
    logic [31:0] digits;
    logic [7:0]  digit_valid;
    logic        frame_done, seg_err, an_err, stale;

    seg_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_out7        (out7),
        .i_en_out      (en_out),
        .o_digits      (digits),
        .o_digit_valid (digit_valid),
        .o_frame_done  (frame_done),
        .o_seg_err     (seg_err),
        .o_an_err      (an_err),
        .o_stale       (stale)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] digits;
        logic [7:0]  valid;
        logic        fd;
        logic        se;
        logic        ae;
        logic        st;
        int          at;
        int          tag;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    logic [6:0]  gl [16];
    logic [31:0] m_digits;
    logic [7:0]  m_valid;
    int          last_cap;
    int          tag_n = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic push(input logic fd, input logic se, input logic ae, input logic st, input int at);
        exp_t e;
        e.digits = m_digits;
        e.valid  = m_valid;
        e.fd = fd; e.se = se; e.ae = ae; e.st = st;
        e.at  = at;
        e.tag = tag_n;
        tag_n++;
        sb_q.push_back(e);
    endtask

    // Present one digit for a dwell; called #1 after a rising edge
    task automatic show(input int digit, input logic [6:0] pat, input logic [3:0] val,
                        input logic legal, input logic fd, input int dwell);
        int d;
        out7   = pat;
        en_out = ~(8'd1 << digit);
        d = cyc;
        if (legal) begin
            m_digits[digit*4 +: 4] = val;
            m_valid[digit] = 1'b1;
            last_cap = d + SETTLE + 2;
            push(fd, 1'b0, 1'b0, 1'b0, d + SETTLE + 2);
        end else begin
            m_valid[digit] = 1'b0;
            push(1'b0, 1'b1, 1'b0, 1'b0, d + SETTLE + 2);
        end
        repeat (dwell) @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [6:0] pat, input logic [7:0] en, input int n);
        out7   = pat;
        en_out = en;
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] p_d;
    logic [7:0]  p_v;
    logic        p_s;
    exp_t        me;

    // Monitor: every pulse or change on the data outputs is one scoreboard event
    always @(negedge clk) begin
        if (rst) begin
            p_d = digits; p_v = digit_valid; p_s = stale;
        end else begin
            if (frame_done || seg_err || an_err || digits !== p_d || digit_valid !== p_v || stale !== p_s) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event cyc=%0d digits=%h valid=%h fd=%b se=%b ae=%b stale=%b",
                             cyc, digits, digit_valid, frame_done, seg_err, an_err, stale);
                end else begin
                    me = sb_q.pop_front();
                    if (cyc != me.at || digits !== me.digits || digit_valid !== me.valid ||
                        frame_done !== me.fd || seg_err !== me.se || an_err !== me.ae || stale !== me.st) begin
                        bad++;
                        $display("FAIL ev%0d got cyc=%0d d=%h v=%h fd%b se%b ae%b st%b want cyc=%0d d=%h v=%h fd%b se%b ae%b st%b",
                                 me.tag, cyc, digits, digit_valid, frame_done, seg_err, an_err, stale,
                                 me.at, me.digits, me.valid, me.fd, me.se, me.ae, me.st);
                    end
                end
            end
            p_d = digits; p_v = digit_valid; p_s = stale;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        gl[0]  = 7'h40; gl[1]  = 7'h79; gl[2]  = 7'h24; gl[3]  = 7'h30;
        gl[4]  = 7'h19; gl[5]  = 7'h12; gl[6]  = 7'h02; gl[7]  = 7'h78;
        gl[8]  = 7'h00; gl[9]  = 7'h10; gl[10] = 7'h08; gl[11] = 7'h03;
        gl[12] = 7'h46; gl[13] = 7'h21; gl[14] = 7'h06; gl[15] = 7'h0E;
        m_digits = 32'd0; m_valid = 8'd0; last_cap = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_digits", digits, 32'd0);
        chk("rst_valid", {24'd0, digit_valid}, 32'd0);
        chk("rst_pulses_stale", {28'd0, frame_done, seg_err, an_err, stale}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full frame of glyphs 0..7
        for (int i = 0; i < 8; i++) show(i, gl[i], 4'(i), 1'b1, (i == 7), DWELL);
        chk("frame1_digits", digits, 32'h76543210);

        // Illegal glyph on digit 3, then overwrite digit 3 twice
        show(3, 7'h7F, 4'h0, 1'b0, 1'b0, DWELL);
        show(3, gl[13], 4'hD, 1'b1, 1'b0, DWELL);
        show(3, gl[3], 4'h3, 1'b1, 1'b0, DWELL);

        // Remaining digits complete a frame whose digit 3 was already seen
        show(0, gl[8],  4'h8, 1'b1, 1'b0, DWELL);
        show(1, gl[9],  4'h9, 1'b1, 1'b0, DWELL);
        show(2, gl[10], 4'hA, 1'b1, 1'b0, DWELL);
        show(4, gl[11], 4'hB, 1'b1, 1'b0, DWELL);
        show(5, gl[12], 4'hC, 1'b1, 1'b0, DWELL);
        show(6, gl[14], 4'hE, 1'b1, 1'b0, DWELL);
        show(7, gl[15], 4'hF, 1'b1, 1'b1, DWELL);
        chk("frame2_digits", digits, 32'hFECB3A98);

        // Two enables low: one an_err; then blanking: no events
        out7 = gl[5]; en_out = 8'hFC;
        push(1'b0, 1'b0, 1'b1, 1'b0, cyc + SETTLE + 2);
        idle(gl[5], 8'hFC, 10);
        idle(gl[5], 8'hFF, 10);

        // Segment lines toggling faster than SETTLE: nothing captured
        for (int k = 0; k < 10; k++) idle(k[0] ? gl[2] : gl[1], 8'hFE, 3);

        // Scanning stops: stale after TIMEOUT cycles from the last capture
        m_valid = 8'd0;
        push(1'b0, 1'b0, 1'b0, 1'b1, last_cap + TIMEOUT);
        w = last_cap + TIMEOUT + 2 - cyc;
        if (w < 1) w = 1;
        idle(7'h7F, 8'hFF, w);
        chk("stale_level", {31'd0, stale}, 32'd1);
        show(2, gl[2], 4'h2, 1'b1, 1'b0, DWELL);

        // Partial frame, then reset mid-frame
        show(0, gl[0], 4'h0, 1'b1, 1'b0, DWELL);
        show(1, gl[1], 4'h1, 1'b1, 1'b0, DWELL);
        show(3, gl[7], 4'h7, 1'b1, 1'b0, DWELL);
        show(4, gl[4], 4'h4, 1'b1, 1'b0, DWELL);
        chk("partial_digits", digits, 32'hFEC47210);
        out7 = 7'h7F; en_out = 8'hFF;
        rst = 1'b1;
        #1;
        chk("midrst_digits", digits, 32'd0);
        chk("midrst_valid", {24'd0, digit_valid}, 32'd0);
        chk("midrst_pulses_stale", {28'd0, frame_done, seg_err, an_err, stale}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        m_digits = 32'd0; m_valid = 8'd0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) show(i, gl[i], 4'(i), 1'b1, (i == 7), DWELL);
        chk("frame3_digits", digits, 32'h76543210);
        chk("frame3_valid", {24'd0, digit_valid}, 32'h000000FF);

        for (int k = 0; k < 100 && sb_q.size() != 0; k++) @(posedge clk);
        #1;
        chk("sb_queue_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SETTLE, 4, cycles both scan inputs must be stable before a digit is sampled (range 1..255).
REQ-002 TIMEOUT, 1048576, cycles without any capture before the display is declared stale.
REQ-003 Clk  input  1  single clock; all logic on rising edge.
REQ-004 Rst  input  1  asynchronous, active-high reset.
REQ-005 out7  input  7  active-low segment pattern, bit6=g ... bit0=a.
REQ-006 en_out  input  8  active-low digit enables, bit i = digit i.
REQ-007 digits  output  32  decoded hex value, digit i at bits [4i+3:4i].
REQ-008 digit_valid  output  8  bit i = digit i captured with a legal pattern and not stale.
REQ-009 frame_done  output  1  one-cycle pulse when all 8 digits have been captured since the previous pulse.
REQ-010 seg_err  output  1  one-cycle pulse when a sampled pattern is not one of the 16 hex glyphs.
REQ-011 an_err  output  1  one-cycle pulse when a stable enable word has more than one bit low.
REQ-012 stale  output  1  level; high once TIMEOUT expires, low after the next capture.

Function
REQ-013 out7/en_out SHALL be registered once; the stability counter SHALL clear when either registered value differs from its previous-cycle value, and increment (saturating) otherwise.
REQ-014 FSM SHALL have states WAIT (settling), SAMPLE (one cycle), HOLD (already sampled this dwell); any input change from any state returns to WAIT.
REQ-015 WAIT->SAMPLE when the counter reaches SETTLE; SAMPLE->HOLD unconditionally.
REQ-016 In SAMPLE with exactly one en_out bit low: legal glyph -> write nibble i, set digit_valid[i] and seen[i]; illegal glyph -> pulse seg_err, clear digit_valid[i], leave nibble and seen unchanged.
REQ-017 In SAMPLE with en_out = 8'hFF (blanking) no action; with two or more bits low -> pulse an_err, no digit update.
REQ-018 Outputs SHALL update on the edge ending SAMPLE: total latency from an input change to digits/errors = SETTLE+2 cycles.
REQ-019 Glyph map (out7 hex -> value): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F; all other codes illegal.
REQ-020 When seen becomes 8'hFF, frame_done SHALL pulse on the same edge as the completing write and seen SHALL clear to 0.
REQ-021 Timeout counter SHALL clear on every legal capture, otherwise increment; on reaching TIMEOUT it sets stale, clears digit_valid and seen, and holds.
REQ-022 Capture and timeout on the same edge: capture wins, stale stays/goes low, counter clears.
REQ-023 Re-capturing an already-seen digit within a frame SHALL overwrite the nibble without affecting seen.

Reset
REQ-024 Rst high SHALL immediately force: digits=0, digit_valid=0, frame_done=0, seg_err=0, an_err=0, stale=0, seen=0, counters=0, FSM=WAIT, input registers = all-ones.
REQ-025 Reset mid-frame SHALL discard partial captures; first frame_done after release requires all 8 digits again.

Structure
REQ-026 Shared package holds glyph constants for 0-F, NUM_DIGITS=8, and FSM state encodings.
REQ-027 Combinational sub-module seg7_to_hex (pattern in; value and legal out) is instantiated once.

Verification
REQ-028 Scan digits 0..7 with glyphs 0..7, dwell 16 cycles each -> digits=32'h76543210, digit_valid=FF, one frame_done at 8th capture.
REQ-029 Digit 3 with out7=7'h7F -> seg_err one pulse at SETTLE+2 cycles, digit_valid[3]=0, nibble 3 unchanged.
REQ-030 en_out=8'hFC stable 10 cycles -> one an_err pulse, digits unchanged; en_out=FF -> no pulses.
REQ-031 Toggle out7 every 3 cycles with SETTLE=4 -> no capture, no errors.
REQ-032 TIMEOUT=100, stop scanning after full frame -> stale=1 and digit_valid=0 at cycle 100; next legal capture -> stale=0.
REQ-033 Assert Rst after 5 digits, release, scan 8 digits -> exactly one frame_done, none before the 8th capture.
